gate_sequence_controller: RTL and testbench

Sequences the 2x2 complex matrix multiplier to fold a list of single-qubit gate matrices into one composite unitary. On `start` it fetches gates from a synchronous gate memory, multiplies each into a running accumulator, and presents the final matrix with a one-cycle `done` pulse. It sits between the compiler's gate memory and the complex matrix multiplier, and is the only driver of the multiplier's inputs.

---
 rtl/gate_sequence_controller.sv | 167 ++++++++++++++++
 tb/tb_gate_sequence_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sequence_controller.sv
// rtl/gate_sequence_controller.sv - folds a list of 2x2 complex gate matrices into one composite unitary
//
// Fetches N gates from a synchronous gate memory and drives the external 2x2
// complex matrix multiplier so that result = G[N-1] * ... * G[0].
// Matrices are packed as [row][col][re/im][18:0], 19-bit signed fixed point.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             begin a sequence (sampled only in IDLE)
//   base_addr         address of gate 0
//   gate_count        number of gates N (0..2^ADDR_W)
//   gate_rd_en        gate memory read strobe
//   gate_addr         gate memory address (base + index, wraps)
//   gate_data         gate matrix, valid the cycle after gate_rd_en
//   mul_a, mul_b      multiplier operands (gate, accumulator)
//   mul_ready         one-cycle multiplier start pulse
//   mul_r             multiplier result
//   mul_completed     multiplier completion
//   result            running / final accumulator
//   busy              high while a sequence is in flight
//   done              one-cycle completion pulse
//   error             multiplier timeout flag, held until next accepted start
module gate_sequence_controller #(
  parameter int ADDR_W    = 8,
  parameter int FRAC_BITS = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [ADDR_W:0]                     gate_count,
  output logic                                gate_rd_en,
  output logic [ADDR_W-1:0]                   gate_addr,
  input  logic signed [0:1][0:1][0:1][18:0]   gate_data,
  output logic signed [0:1][0:1][0:1][18:0]   mul_a,
  output logic signed [0:1][0:1][0:1][18:0]   mul_b,
  output logic                                mul_ready,
  input  logic signed [0:1][0:1][0:1][18:0]   mul_r,
  input  logic                                mul_completed,
  output logic signed [0:1][0:1][0:1][18:0]   result,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  typedef logic signed [0:1][0:1][0:1][18:0] mat_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MUL,
    WAIT,
    DONE
  } state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [18:0] ONE = 19'(1 << FRAC_BITS);

  function automatic mat_t identity();
    mat_t m;
    m          = '0;
    m[0][0][0] = ONE;
    m[1][1][0] = ONE;
    return m;
  endfunction

  state_t            state;
  state_t            state_next;
  mat_t              acc;
  mat_t              gate_reg;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   index_inc;
  logic [TW-1:0]     wait_cnt;
  logic              wait_expired;

  assign index_inc    = index + 1'b1;
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (gate_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = MUL;
      MUL:   state_next = WAIT;
      WAIT: begin
        // Completion wins over an expiring counter on the same cycle.
        if (mul_completed) begin
          state_next = (index_inc < count_q) ? FETCH : DONE;
        end else if (wait_expired) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= identity();
      gate_reg <= '0;
      base_q   <= '0;
      count_q  <= '0;
      index    <= '0;
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= gate_count;
            acc     <= identity();
            index   <= '0;
            error   <= 1'b0;
          end
        end
        LOAD: gate_reg <= gate_data;
        MUL:  wait_cnt <= '0;
        WAIT: begin
          if (mul_completed) begin
            acc   <= mul_r;
            index <= index_inc;
          end else if (wait_expired) begin
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address wraps naturally at 2^ADDR_W because only the low index bits are added.
  assign gate_addr  = base_q + index[ADDR_W-1:0];
  assign gate_rd_en = (state == FETCH);
  assign mul_ready  = (state == MUL);

  // Operands are only presented while a multiply is in flight; gate_reg and
  // acc do not change between MUL and the completion edge, so they hold steady.
  assign mul_a = ((state == MUL) || (state == WAIT)) ? gate_reg : '0;
  assign mul_b = ((state == MUL) || (state == WAIT)) ? acc : '0;

  assign result = acc;
  assign busy   = (state == FETCH) || (state == LOAD) || (state == MUL) || (state == WAIT);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_gate_sequence_controller.sv
// tb/tb_gate_sequence_controller.sv - scoreboard bench for gate_sequence_controller
module tb_gate_sequence_controller;

  typedef logic [0:1][0:1][0:1][18:0] mat_t;

  typedef struct {
    mat_t res;
    int   err;
    int   cyc;
  } exp_t;

  localparam int TIMEOUT = 8;
  localparam int ONE     = 1 << 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  gate_count;
  logic        gate_rd_en;
  logic [7:0]  gate_addr;
  mat_t        gate_data;
  mat_t        mul_a;
  mat_t        mul_b;
  logic        mul_ready;
  mat_t        mul_r;
  logic        mul_completed;
  mat_t        result;
  logic        busy;
  logic        done;
  logic        error;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_cnt   = 0;

  mat_t mem [256];
  bit   mul_en = 1'b1;
  logic pend;
  mat_t prod;

  exp_t       exp_q [$];
  logic [7:0] addr_q [$];
  mat_t       op_q [$];

  mat_t m_i, m_x, m_z, m_zx, m_negz;

  gate_sequence_controller #(
    .ADDR_W(8), .FRAC_BITS(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .gate_count(gate_count), .gate_rd_en(gate_rd_en), .gate_addr(gate_addr),
    .gate_data(gate_data), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
    .mul_r(mul_r), .mul_completed(mul_completed), .result(result),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic mat_t mk(input int r00, input int r01, input int r10, input int r11);
    mat_t m;
    m          = '0;
    m[0][0][0] = 19'(r00);
    m[0][1][0] = 19'(r01);
    m[1][0][0] = 19'(r10);
    m[1][1][0] = 19'(r11);
    return m;
  endfunction

  function automatic mat_t cmul(input mat_t a, input mat_t b);
    mat_t   r;
    longint sr, si, ar, ai, br, bi;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        sr = 0;
        si = 0;
        for (int k = 0; k < 2; k++) begin
          ar = longint'($signed(a[i][k][0]));
          ai = longint'($signed(a[i][k][1]));
          br = longint'($signed(b[k][j][0]));
          bi = longint'($signed(b[k][j][1]));
          sr = sr + ar * br - ai * bi;
          si = si + ar * bi + ai * br;
        end
        r[i][j][0] = 19'(sr >>> 16);
        r[i][j][1] = 19'(si >>> 16);
      end
    end
    return r;
  endfunction

  // Synchronous gate memory.
  always @(posedge clk) begin
    if (gate_rd_en) gate_data <= mem[gate_addr];
  end

  // Multiplier: completion two cycles after mul_ready; never completes when mul_en=0.
  always @(posedge clk) begin
    if (reset) begin
      pend          <= 1'b0;
      mul_completed <= 1'b0;
    end else begin
      pend          <= mul_ready && mul_en;
      mul_completed <= pend;
      if (mul_ready) prod <= cmul(mul_a, mul_b);
      if (pend) mul_r <= prod;
    end
  end

  task automatic chk_m(input string nm, input mat_t act, input mat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a read, a multiply or a done.
  bit         tracking = 1'b0;
  mat_t       hold_a, hold_b, g;
  logic [7:0] a;
  exp_t       e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        tracking = 1'b0;
      end else begin
        if (gate_rd_en) begin
          if (addr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_read: got addr %0h, expected no read", gate_addr);
          end else begin
            a = addr_q.pop_front();
            chk_v("gate_addr", int'(gate_addr), int'(a));
          end
        end
        if (!busy) begin
          tracking = 1'b0;
        end else if (tracking) begin
          chk_m("mul_a_stable", mul_a, hold_a);
          chk_m("mul_b_stable", mul_b, hold_b);
        end
        if (mul_completed) tracking = 1'b0;
        if (mul_ready) begin
          if (op_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_mul: got mul_ready=1, expected 0");
          end else begin
            g = op_q.pop_front();
            chk_m("mul_a_gate", mul_a, g);
          end
          hold_a   = mul_a;
          hold_b   = mul_b;
          tracking = 1'b1;
        end
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
          end else begin
            e = exp_q.pop_front();
            chk_m("result", result, e.res);
            chk_v("error", int'(error), e.err);
            chk_v("done_cycle", cyc, e.cyc);
            chk_v("busy_at_done", int'(busy), 0);
          end
        end
      end
    end
  end

  task automatic run_seq(input logic [7:0] base, input int n, input mat_t exp_res,
                         input int exp_err, input int lat, input bit poke);
    int   seen;
    exp_t x;
    @(negedge clk);
    seen       = done_cnt;
    base_addr  = base;
    gate_count = 9'(n);
    start      = 1'b1;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(8'(base + 8'(i)));
      op_q.push_back(mem[8'(base + 8'(i))]);
    end
    x.res = exp_res;
    x.err = exp_err;
    x.cyc = cyc + lat;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      base_addr  = 8'h20;
      gate_count = 9'd1;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 400 && done_cnt == seen; k++) @(negedge clk);
    if (done_cnt == seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, expected done at cycle %0d", x.cyc);
    end
    @(negedge clk);
  endtask

  int s;

  initial begin
    m_i    = mk(ONE, 0, 0, ONE);
    m_x    = mk(0, ONE, ONE, 0);
    m_z    = mk(ONE, 0, 0, -ONE);
    m_zx   = mk(0, ONE, -ONE, 0);
    m_negz = mk(-ONE, 0, 0, ONE);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = m_x;
    mem[8'h20] = m_x;
    mem[8'h30] = m_x;
    mem[8'h31] = m_x;
    mem[8'h40] = m_x;
    mem[8'h41] = m_z;
    mem[8'hFF] = m_x;
    mem[8'h00] = m_z;
    mem[8'h01] = m_x;
    mem[8'h50] = m_x;
    mem[8'h51] = m_x;
    mem[8'h52] = m_x;
    mul_r      = '0;
    gate_data  = '0;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    gate_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk_m("reset_result", result, m_i);
    chk_m("reset_mul_a", mul_a, '0);
    chk_m("reset_mul_b", mul_b, '0);
    chk_v("reset_busy", int'(busy), 0);
    chk_v("reset_done", int'(done), 0);
    chk_v("reset_error", int'(error), 0);
    chk_v("reset_mul_ready", int'(mul_ready), 0);
    chk_v("reset_gate_rd_en", int'(gate_rd_en), 0);
    chk_v("reset_gate_addr", int'(gate_addr), 0);

    run_seq(8'h00, 0, m_i, 0, 1, 1'b0);
    run_seq(8'h20, 1, m_x, 0, 6, 1'b0);
    run_seq(8'h30, 2, m_i, 0, 11, 1'b0);
    run_seq(8'h40, 2, m_zx, 0, 11, 1'b0);
    run_seq(8'hFF, 3, m_negz, 0, 16, 1'b1);

    mul_en = 1'b0;
    run_seq(8'h10, 1, m_i, 1, 3 + TIMEOUT + 1, 1'b0);
    mul_en = 1'b1;
    run_seq(8'h00, 0, m_i, 0, 1, 1'b0);

    // Abort during the WAIT of the second gate of three.
    @(negedge clk);
    base_addr  = 8'h50;
    gate_count = 9'd3;
    start      = 1'b1;
    s          = cyc;
    addr_q.push_back(8'h50);
    addr_q.push_back(8'h51);
    op_q.push_back(m_x);
    op_q.push_back(m_x);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    chk_v("abort_in_wait_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_v("abort_busy", int'(busy), 0);
    chk_v("abort_mul_ready", int'(mul_ready), 0);
    chk_v("abort_done", int'(done), 0);
    chk_v("abort_gate_rd_en", int'(gate_rd_en), 0);
    chk_v("abort_gate_addr", int'(gate_addr), 0);
    chk_m("abort_result", result, m_i);
    chk_v("abort_pending_reads", addr_q.size(), 0);

    run_seq(8'h50, 3, m_x, 0, 16, 1'b0);

    repeat (3) @(negedge clk);
    chk_v("leftover_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
